// File: rtl/btn_ctrl.sv
// Two-button debouncer with press strobe and auto-repeat; strobes are suppressed
// while both debounced levels are high.
module btn_ctrl #(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int REPEAT_DELAY    = 19500000,
    parameter int REPEAT_PERIOD   = 6500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btnL,
    input  logic btnR,
    output logic left_lvl,
    output logic right_lvl,
    output logic left_pulse,
    output logic right_pulse
);

    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    // index 0 = left, 1 = right
    logic [1:0]    raw;
    logic [1:0]    sync1, sync2, lvl;
    logic [1:0]    lvl_nxt, rise, fall, ipulse;
    logic [DW-1:0] cnt [2];
    logic [TW-1:0] tmr [2];
    state_t        st  [2];

    assign raw = {btnR, btnL};

    // Level, edges and FSM pulse are all derived from next-state values so the
    // press strobe lands in the same cycle the registered level first reads 1.
    always_comb begin
        lvl_nxt = lvl;
        rise    = '0;
        fall    = '0;
        ipulse  = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (sync2[i] != lvl[i] && cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                lvl_nxt[i] = ~lvl[i];
                rise[i]    = sync2[i];
                fall[i]    = ~sync2[i];
            end
            case (st[i])
                IDLE:    ipulse[i] = rise[i];
                DELAY:   ipulse[i] = ~fall[i] && tmr[i] == TW'(REPEAT_DELAY - 1);
                REPEAT:  ipulse[i] = ~fall[i] && tmr[i] == TW'(REPEAT_PERIOD - 1);
                default: ipulse[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= '0;
            sync2       <= '0;
            lvl         <= '0;
            left_lvl    <= 1'b0;
            right_lvl   <= 1'b0;
            left_pulse  <= 1'b0;
            right_pulse <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt[i] <= '0;
                tmr[i] <= '0;
                st[i]  <= IDLE;
            end
        end else begin
            sync1       <= raw;
            sync2       <= sync1;
            lvl         <= lvl_nxt;
            left_lvl    <= lvl_nxt[0];
            right_lvl   <= lvl_nxt[1];
            left_pulse  <= ipulse[0] & ~(lvl_nxt[0] & lvl_nxt[1]);
            right_pulse <= ipulse[1] & ~(lvl_nxt[0] & lvl_nxt[1]);
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == lvl[i] || lvl_nxt[i] != lvl[i])
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + DW'(1);

                case (st[i])
                    IDLE: begin
                        tmr[i] <= '0;
                        if (rise[i])
                            st[i] <= DELAY;
                    end
                    DELAY: begin
                        if (fall[i]) begin
                            st[i]  <= IDLE;
                            tmr[i] <= '0;
                        end else if (tmr[i] == TW'(REPEAT_DELAY - 1)) begin
                            st[i]  <= REPEAT;
                            tmr[i] <= '0;
                        end else begin
                            tmr[i] <= tmr[i] + TW'(1);
                        end
                    end
                    REPEAT: begin
                        if (fall[i]) begin
                            st[i]  <= IDLE;
                            tmr[i] <= '0;
                        end else if (tmr[i] == TW'(REPEAT_PERIOD - 1)) begin
                            tmr[i] <= '0;
                        end else begin
                            tmr[i] <= tmr[i] + TW'(1);
                        end
                    end
                    default: begin
                        st[i]  <= IDLE;
                        tmr[i] <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_btn_ctrl.sv
// Directed bench for btn_ctrl with small timing parameters; each scenario is a
// per-cycle stimulus/expectation table, bit k describing cycle k.
module tb_btn_ctrl;

    logic clk = 1'b0;
    logic rst, btnL, btnR;
    logic left_lvl, right_lvl, left_pulse, right_pulse;

    int checks   = 0;
    int failures = 0;

    btn_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btnL       (btnL),
        .btnR       (btnR),
        .left_lvl   (left_lvl),
        .right_lvl  (right_lvl),
        .left_pulse (left_pulse),
        .right_pulse(right_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rng(input int a, input int b);
        logic [63:0] m = '0;
        for (int k = a; k <= b; k++) m[k] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] bt(input int k);
        logic [63:0] m = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // Outputs are checked 1 time unit after edge k (cycle k), then inputs for
    // cycle k are driven and get sampled on edge k+1.
    task automatic run(input string name, input int n,
                       input logic [63:0] l, input logic [63:0] r, input logic [63:0] rs,
                       input logic [63:0] ell, input logic [63:0] erl,
                       input logic [63:0] elp, input logic [63:0] erp);
        rst  = 1'b1;
        btnL = 1'b0;
        btnR = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < n; i++) begin
            chk({name, ".left_lvl"},    i, left_lvl,    ell[i]);
            chk({name, ".right_lvl"},   i, right_lvl,   erl[i]);
            chk({name, ".left_pulse"},  i, left_pulse,  elp[i]);
            chk({name, ".right_pulse"}, i, right_pulse, erp[i]);
            rst  = rs[i];
            btnL = l[i];
            btnR = r[i];
            tick();
        end
    endtask

    initial begin
        rst  = 1'b1;
        btnL = 1'b0;
        btnR = 1'b0;
        tick();

        // clean press of 8 cycles: one press pulse, no repeat
        run("press", 24, rng(0, 7), '0, '0,
            rng(6, 13), '0, bt(6), '0);

        // bouncing right button; level follows final rising edge at cycle 8
        run("bounce", 30, '0, rng(0, 1) | rng(4, 5) | rng(8, 15), '0,
            '0, rng(14, 21), '0, bt(14));

        // 3-cycle glitch is shorter than the debounce window
        run("glitch", 16, rng(2, 4), '0, '0,
            '0, '0, '0, '0);

        // long hold: press, delayed repeat, periodic repeat, release
        run("repeat", 45, rng(0, 29), '0, '0,
            rng(6, 35), '0, bt(6) | bt(16) | bt(21) | bt(26) | bt(31), '0);

        // overlap with right: pulses suppressed while both levels are high
        run("both", 42, rng(0, 27), rng(6, 13), '0,
            rng(6, 33), rng(12, 19), bt(6) | bt(21) | bt(26) | bt(31), '0);

        // reset mid-sequence while held: fresh press after release of reset
        run("reset", 56, rng(0, 45), '0, bt(18),
            rng(6, 18) | rng(25, 51), '0,
            bt(6) | bt(16) | bt(25) | bt(35) | bt(40) | bt(45) | bt(50), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
